// File: rtl/mipi_csi_pkg.sv
// Shared CSI-2 receive definitions: data types, packet FSM states and register offsets.
package mipi_csi_pkg;

   localparam logic [5:0] DT_FS       = 6'h00;
   localparam logic [5:0] DT_FE       = 6'h01;
   localparam logic [5:0] DT_LS       = 6'h02;
   localparam logic [5:0] DT_LE       = 6'h03;
   localparam logic [5:0] DT_RAW10    = 6'h2B;
   localparam logic [5:0] LONG_DT_MIN = 6'h10;

   typedef enum logic [1:0] {IDLE, PAYLOAD, DROP} pkt_state_e;

   localparam logic [1:0] REG_CTRL = 2'd0;
   localparam logic [1:0] REG_CNT  = 2'd1;
   localparam logic [1:0] REG_ERR  = 2'd2;

   // RAW10 packs 4 pixels into 5 bytes, so only whole groups are unpackable.
   function automatic logic wc_valid(input logic [15:0] wc);
      return (wc != 16'd0) && ((wc % 16'd5) == 16'd0);
   endfunction

endpackage

// File: rtl/mipi_rx_ctrl_regs.sv
// Wishbone slave window: CTRL (RW), CNT (RO), ERR (W1C sticky flags).
module mipi_rx_ctrl_regs
   import mipi_csi_pkg::*;
#(
   parameter logic [5:0] DEFAULT_DT = 6'h2B,
   parameter logic [1:0] DEFAULT_VC = 2'd0,
   parameter int         CNT_W      = 16
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_ni,
   input  logic             wbs_stb_i,
   input  logic             wbs_cyc_i,
   input  logic             wbs_we_i,
   input  logic [3:0]       wbs_sel_i,
   input  logic [31:0]      wbs_adr_i,
   input  logic [31:0]      wbs_dat_i,
   output logic             wbs_ack_o,
   output logic [31:0]      wbs_dat_o,
   input  logic [CNT_W-1:0] frame_count,
   input  logic [CNT_W-1:0] line_count,
   input  logic             wc_err_set,
   input  logic             seq_err_set,
   output logic             en,
   output logic [1:0]       vc,
   output logic [5:0]       dt
);

   // Handshake: a request is stb && cyc; it is serviced on the first cycle it is
   // seen with ack low, and ack is high for exactly the following cycle.
   logic        wb_access;
   logic        wb_wr;
   logic        wc_err;
   logic        seq_err;
   logic [31:0] rd_data;
   logic [31:0] cnt_word;
   logic        unused_bits;

   assign wb_access   = wbs_stb_i && wbs_cyc_i && !wbs_ack_o;
   assign wb_wr       = wb_access && wbs_we_i;
   assign unused_bits = &{1'b0, wbs_adr_i[31:4], wbs_adr_i[1:0], wbs_dat_i[31:9], wbs_sel_i[3:2]};

   always_comb begin
      cnt_word = '0;
      cnt_word[CNT_W-1:0]  = frame_count;
      cnt_word[16 +: CNT_W] = line_count;
   end

   always_comb begin
      rd_data = '0;
      case (wbs_adr_i[3:2])
         REG_CTRL: rd_data = {23'd0, dt, vc, en};
         REG_CNT:  rd_data = cnt_word;
         REG_ERR:  rd_data = {30'd0, seq_err, wc_err};
         default:  rd_data = '0;
      endcase
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         wbs_ack_o <= 1'b0;
         wbs_dat_o <= '0;
         en        <= 1'b0;
         vc        <= DEFAULT_VC;
         dt        <= DEFAULT_DT;
         wc_err    <= 1'b0;
         seq_err   <= 1'b0;
      end else begin
         wbs_ack_o <= wb_access;
         wbs_dat_o <= (wb_access && !wbs_we_i) ? rd_data : '0;
         if (wb_wr && wbs_adr_i[3:2] == REG_CTRL) begin
            if (wbs_sel_i[0]) {dt[4:0], vc, en} <= wbs_dat_i[7:0];
            if (wbs_sel_i[1]) dt[5] <= wbs_dat_i[8];
         end
         // A hardware set in the same cycle as a clear wins.
         if (wb_wr && wbs_adr_i[3:2] == REG_ERR && wbs_sel_i[0]) begin
            wc_err  <= wc_err_set  | (wc_err  & ~wbs_dat_i[0]);
            seq_err <= seq_err_set | (seq_err & ~wbs_dat_i[1]);
         end else begin
            wc_err  <= wc_err  | wc_err_set;
            seq_err <= seq_err | seq_err_set;
         end
      end
   end

endmodule

// File: rtl/mipi_rx_packet_ctrl.sv
// CSI-2 packet controller: decodes short packets, gates matching RAW10 payload to the unpacker.
module mipi_rx_packet_ctrl
   import mipi_csi_pkg::*;
#(
   parameter logic [5:0] DEFAULT_DT = 6'h2B,
   parameter logic [1:0] DEFAULT_VC = 2'd0,
   parameter int         CNT_W      = 16
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_ni,
   input  logic        word_valid_i,
   input  logic [31:0] word_i,
   output logic        unpack_valid_o,
   output logic [31:0] unpack_data_o,
   output logic        frame_start_o,
   output logic        frame_end_o,
   output logic        line_start_o,
   output logic        line_end_o,
   output logic        busy_o,
   input  logic        wbs_stb_i,
   input  logic        wbs_cyc_i,
   input  logic        wbs_we_i,
   input  logic [3:0]  wbs_sel_i,
   input  logic [31:0] wbs_adr_i,
   input  logic [31:0] wbs_dat_i,
   output logic        wbs_ack_o,
   output logic [31:0] wbs_dat_o
);

   pkt_state_e       state;
   logic [16:0]      rem;
   logic [16:0]      pos;
   logic [15:0]      wc;
   logic [CNT_W-1:0] frame_count;
   logic [CNT_W-1:0] line_count;
   logic             en;
   logic [1:0]       vc;
   logic [5:0]       dt;
   logic             wc_err_set;
   logic             seq_err_set;

   logic [1:0]  hdr_vc;
   logic [5:0]  hdr_dt;
   logic [15:0] hdr_wc;
   logic        hdr_long;
   logic        hdr_match;

   assign hdr_vc    = word_i[7:6];
   assign hdr_dt    = word_i[5:0];
   assign hdr_wc    = word_i[23:8];
   assign hdr_long  = hdr_dt >= LONG_DT_MIN;
   assign hdr_match = (hdr_vc == vc) && (hdr_dt == dt);
   assign busy_o    = state != IDLE;

   assign wc_err_set  = en && word_valid_i && state == IDLE && hdr_long && hdr_match && !wc_valid(hdr_wc);
   assign seq_err_set = en && !word_valid_i && state == PAYLOAD;

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state          <= IDLE;
         rem            <= '0;
         pos            <= '0;
         wc             <= '0;
         frame_count    <= '0;
         line_count     <= '0;
         unpack_valid_o <= 1'b0;
         unpack_data_o  <= '0;
         frame_start_o  <= 1'b0;
         frame_end_o    <= 1'b0;
         line_start_o   <= 1'b0;
         line_end_o     <= 1'b0;
      end else begin
         unpack_valid_o <= 1'b0;
         frame_start_o  <= 1'b0;
         frame_end_o    <= 1'b0;
         line_start_o   <= 1'b0;
         line_end_o     <= 1'b0;
         if (!en) begin
            state <= IDLE;
         end else begin
            case (state)
               IDLE: if (word_valid_i) begin
                  if (!hdr_long) begin
                     if (hdr_vc == vc) begin
                        case (hdr_dt)
                           DT_FS: begin
                              frame_start_o <= 1'b1;
                              line_count    <= '0;
                           end
                           DT_FE: begin
                              frame_end_o <= 1'b1;
                              frame_count <= frame_count + 1'b1;
                           end
                           DT_LS:   line_start_o <= 1'b1;
                           DT_LE:   line_end_o   <= 1'b1;
                           default: ;
                        endcase
                     end
                  end else begin
                     // rem counts payload plus the 2-byte CRC still to come.
                     rem   <= {1'b0, hdr_wc} + 17'd2;
                     pos   <= '0;
                     wc    <= hdr_wc;
                     state <= (hdr_match && wc_valid(hdr_wc)) ? PAYLOAD : DROP;
                  end
               end
               PAYLOAD, DROP: if (word_valid_i) begin
                  rem <= rem - 17'd4;
                  pos <= pos + 17'd4;
                  if (state == PAYLOAD && pos < {1'b0, wc}) begin
                     unpack_valid_o <= 1'b1;
                     unpack_data_o  <= word_i;
                  end
                  if (rem <= 17'd4) begin
                     state <= IDLE;
                     if (state == PAYLOAD) line_count <= line_count + 1'b1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   mipi_rx_ctrl_regs #(
      .DEFAULT_DT(DEFAULT_DT),
      .DEFAULT_VC(DEFAULT_VC),
      .CNT_W     (CNT_W)
   ) u_regs (
      .wb_clk_i   (wb_clk_i),
      .wb_rst_ni  (wb_rst_ni),
      .wbs_stb_i  (wbs_stb_i),
      .wbs_cyc_i  (wbs_cyc_i),
      .wbs_we_i   (wbs_we_i),
      .wbs_sel_i  (wbs_sel_i),
      .wbs_adr_i  (wbs_adr_i),
      .wbs_dat_i  (wbs_dat_i),
      .wbs_ack_o  (wbs_ack_o),
      .wbs_dat_o  (wbs_dat_o),
      .frame_count(frame_count),
      .line_count (line_count),
      .wc_err_set (wc_err_set),
      .seq_err_set(seq_err_set),
      .en         (en),
      .vc         (vc),
      .dt         (dt)
   );

endmodule

// File: tb/tb_mipi_rx_packet_ctrl.sv
// Self-checking bench for mipi_rx_packet_ctrl: short-packet strobes, payload gating, registers.
module tb_mipi_rx_packet_ctrl;

   localparam logic [31:0] ADR_CTRL = 32'h0;
   localparam logic [31:0] ADR_CNT  = 32'h4;
   localparam logic [31:0] ADR_ERR  = 32'h8;

   logic        wb_clk_i = 1'b0;
   logic        wb_rst_ni;
   logic        word_valid_i;
   logic [31:0] word_i;
   logic        unpack_valid_o;
   logic [31:0] unpack_data_o;
   logic        frame_start_o, frame_end_o, line_start_o, line_end_o;
   logic        busy_o;
   logic        wbs_stb_i, wbs_cyc_i, wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_adr_i, wbs_dat_i;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q[$];

   mipi_rx_packet_ctrl dut (
      .wb_clk_i      (wb_clk_i),
      .wb_rst_ni     (wb_rst_ni),
      .word_valid_i  (word_valid_i),
      .word_i        (word_i),
      .unpack_valid_o(unpack_valid_o),
      .unpack_data_o (unpack_data_o),
      .frame_start_o (frame_start_o),
      .frame_end_o   (frame_end_o),
      .line_start_o  (line_start_o),
      .line_end_o    (line_end_o),
      .busy_o        (busy_o),
      .wbs_stb_i     (wbs_stb_i),
      .wbs_cyc_i     (wbs_cyc_i),
      .wbs_we_i      (wbs_we_i),
      .wbs_sel_i     (wbs_sel_i),
      .wbs_adr_i     (wbs_adr_i),
      .wbs_dat_i     (wbs_dat_i),
      .wbs_ack_o     (wbs_ack_o),
      .wbs_dat_o     (wbs_dat_o)
   );

   // Clock / reset
   always #5 wb_clk_i = ~wb_clk_i;

   // Scoreboard: every forwarded payload word must match the head of exp_q.
   always @(negedge wb_clk_i) begin
      if (wb_rst_ni === 1'b1 && unpack_valid_o === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unpack_unexpected got=%h want=none", unpack_data_o);
         end else begin
            logic [31:0] e;
            e = exp_q.pop_front();
            if (unpack_data_o !== e) begin
               errors++;
               $display("FAIL unpack_data got=%h want=%h", unpack_data_o, e);
            end
         end
      end
   end

   // Driver tasks: all start and end 1 time unit after a rising edge.
   task automatic drive_word(input logic [31:0] w, input logic fwd);
      word_valid_i = 1'b1;
      word_i       = w;
      if (fwd) exp_q.push_back(w);
      @(posedge wb_clk_i);
      #1;
   endtask

   task automatic idle_cycle();
      word_valid_i = 1'b0;
      word_i       = $urandom;
      @(posedge wb_clk_i);
      #1;
   endtask

   task automatic wb_cycle(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                           input logic [3:0] sel, output logic [31:0] rdat);
      int n;
      wbs_stb_i = 1'b1;
      wbs_cyc_i = 1'b1;
      wbs_we_i  = we;
      wbs_adr_i = adr;
      wbs_dat_i = wdat;
      wbs_sel_i = sel;
      n = 0;
      do begin
         @(posedge wb_clk_i);
         #1;
         n++;
      end while (wbs_ack_o !== 1'b1 && n < 8);
      if (wbs_ack_o !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL wb_ack_timeout got=%b want=1", wbs_ack_o);
      end
      rdat      = wbs_dat_o;
      wbs_stb_i = 1'b0;
      wbs_cyc_i = 1'b0;
      wbs_we_i  = 1'b0;
   endtask

   task automatic wb_write(input logic [31:0] adr, input logic [31:0] wdat);
      logic [31:0] dummy;
      wb_cycle(1'b1, adr, wdat, 4'hF, dummy);
   endtask

   task automatic check_reg(input string name, input logic [31:0] adr, input logic [31:0] want);
      logic [31:0] got;
      wb_cycle(1'b0, adr, 32'h0, 4'hF, got);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%h want=%h", name, got, want);
      end
   endtask

   task automatic test_reset();
      wb_rst_ni = 1'b0;
      word_valid_i = 1'b0; word_i = '0;
      wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
      wbs_sel_i = '0; wbs_adr_i = '0; wbs_dat_i = '0;
      repeat (3) @(posedge wb_clk_i);
      #1;
      checks++;
      if ({unpack_valid_o, unpack_data_o, frame_start_o, frame_end_o, line_start_o, line_end_o,
           busy_o, wbs_ack_o, wbs_dat_o} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got=nonzero want=0");
      end
      wb_rst_ni = 1'b1;
      @(posedge wb_clk_i);
      #1;
      check_reg("reset_ctrl", ADR_CTRL, 32'h0000_0158);
      check_reg("reset_cnt", ADR_CNT, 32'h0);
   endtask

   task automatic test_short_packets();
      logic [3:0] got;
      wb_write(ADR_CTRL, 32'h0000_0159);
      for (int i = 0; i < 4; i++) begin
         drive_word(32'(i) | ($urandom & 32'hFF00_0000), 1'b0);
         word_valid_i = 1'b0;
         got = {frame_start_o, frame_end_o, line_start_o, line_end_o};
         checks++;
         if (got !== (4'b1000 >> i)) begin
            errors++;
            $display("FAIL short_strobe dt=%0d got=%b want=%b", i, got, 4'b1000 >> i);
         end
         idle_cycle();
         got = {frame_start_o, frame_end_o, line_start_o, line_end_o};
         checks++;
         if (got !== 4'b0000) begin
            errors++;
            $display("FAIL short_strobe_width dt=%0d got=%b want=0000", i, got);
         end
      end
      drive_word(32'h0000_0040, 1'b0);
      idle_cycle();
      check_reg("short_vc_mismatch_cnt", ADR_CNT, 32'h0000_0001);
   endtask

   task automatic test_payload();
      drive_word(32'h5A00_0A2B, 1'b0);
      checks++;
      if (busy_o !== 1'b1) begin
         errors++;
         $display("FAIL payload_busy got=%b want=1", busy_o);
      end
      drive_word(32'hA0A1_A2A3, 1'b1);
      drive_word(32'hB0B1_B2B3, 1'b1);
      drive_word(32'hC0C1_C2C3, 1'b1);
      checks++;
      if (busy_o !== 1'b0) begin
         errors++;
         $display("FAIL payload_busy_end got=%b want=0", busy_o);
      end
      idle_cycle();
      check_reg("payload_cnt", ADR_CNT, 32'h0001_0001);
   endtask

   task automatic test_bad_wc();
      drive_word(32'h0000_072B, 1'b0);
      for (int i = 0; i < 3; i++) drive_word($urandom, 1'b0);
      idle_cycle();
      check_reg("wc_err_set", ADR_ERR, 32'h1);
      wb_write(ADR_ERR, 32'h1);
      check_reg("wc_err_clear", ADR_ERR, 32'h0);
      check_reg("wc_err_cnt", ADR_CNT, 32'h0001_0001);
   endtask

   task automatic test_vc_mismatch();
      drive_word(32'h0000_0A6B, 1'b0);
      for (int i = 0; i < 3; i++) drive_word($urandom, 1'b0);
      idle_cycle();
      check_reg("vc_drop_err", ADR_ERR, 32'h0);
      check_reg("vc_drop_cnt", ADR_CNT, 32'h0001_0001);
      drive_word(32'h0000_0A2B, 1'b0);
      for (int i = 0; i < 3; i++) drive_word($urandom, 1'b1);
      idle_cycle();
      check_reg("vc_next_cnt", ADR_CNT, 32'h0002_0001);
   endtask

   task automatic test_en_clear();
      logic [31:0] rd;
      drive_word(32'h0000_142B, 1'b0);
      drive_word($urandom, 1'b1);
      drive_word($urandom, 1'b1);
      fork
         wb_cycle(1'b1, ADR_CTRL, 32'h0000_0158, 4'hF, rd);
         begin
            drive_word($urandom, 1'b1);
            drive_word($urandom, 1'b0);
            checks++;
            if (unpack_valid_o !== 1'b0 || busy_o !== 1'b0) begin
               errors++;
               $display("FAIL en_clear_stop got=%b%b want=00", unpack_valid_o, busy_o);
            end
            drive_word($urandom, 1'b0);
            word_valid_i = 1'b0;
         end
      join
      check_reg("en_clear_cnt", ADR_CNT, 32'h0002_0001);
      check_reg("en_clear_err", ADR_ERR, 32'h0);
      wb_write(ADR_CTRL, 32'h0000_0159);
   endtask

   task automatic test_gap();
      drive_word(32'h0000_0A2B, 1'b0);
      drive_word($urandom, 1'b1);
      repeat (2) idle_cycle();
      drive_word($urandom, 1'b1);
      drive_word($urandom, 1'b1);
      idle_cycle();
      check_reg("gap_seq_err", ADR_ERR, 32'h2);
      check_reg("gap_cnt", ADR_CNT, 32'h0003_0001);
      wb_write(ADR_ERR, 32'h2);
      check_reg("gap_seq_clear", ADR_ERR, 32'h0);
      drive_word(32'h0000_0000, 1'b0);
      idle_cycle();
      check_reg("fs_line_clear", ADR_CNT, 32'h0000_0001);
   endtask

   task automatic test_async_reset();
      drive_word(32'h0000_0A2B, 1'b0);
      drive_word(32'h1234_5678, 1'b0);
      word_valid_i = 1'b0;
      #2;
      wb_rst_ni = 1'b0;
      #1;
      checks++;
      if ({unpack_valid_o, unpack_data_o, busy_o} !== '0) begin
         errors++;
         $display("FAIL async_reset got=%b/%h/%b want=0", unpack_valid_o, unpack_data_o, busy_o);
      end
      exp_q.delete();
      @(posedge wb_clk_i);
      #3;
      wb_rst_ni = 1'b1;
      @(posedge wb_clk_i);
      #1;
      check_reg("async_reset_ctrl", ADR_CTRL, 32'h0000_0158);
      check_reg("async_reset_cnt", ADR_CNT, 32'h0);
   endtask

   initial begin
      test_reset();
      test_short_packets();
      test_payload();
      test_bad_wc();
      test_vc_mismatch();
      test_en_clear();
      test_gap();
      repeat (3) idle_cycle();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL unpack_missing got=%0d want=0", exp_q.size());
      end
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mipi_rx_packet_ctrl.md
Name: mipi_rx_packet_ctrl

Overview:
- CSI-2 packet-level controller that sits in front of the RAW10 unpacker (mipi_rx_raw10_select).
- Parses 32-bit packet words from the lane merger and decodes short packets (FS/FE/LS/LE) into strobes.
- Gates only matching RAW10 long-packet payload words into the unpacker, and drops mismatched or malformed packets.
- Exposes control, frame/line counters and sticky errors through a Wishbone slave register window.

Parameters:
- DEFAULT_DT, 6'h2B: reset value of the accepted data type (RAW10).
- DEFAULT_VC, 2'd0: reset value of the accepted virtual channel.
- CNT_W, 16: width of the frame and line counters.

Ports:
- wb_clk_i  in  1  single clock for the whole block.
- wb_rst_ni  in  1  reset; asynchronous assert, active-low.
- word_valid_i  in  1  packet word valid.
- word_i  in  32  packet word. Byte0 = word_i[7:0] is the first lane byte.
- unpack_valid_o  out  1  drives unpacker data_valid_i.
- unpack_data_o  out  32  drives unpacker data_i.
- frame_start_o  out  1  one-cycle pulse per FS.
- frame_end_o  out  1  one-cycle pulse per FE.
- line_start_o  out  1  one-cycle pulse per LS.
- line_end_o  out  1  one-cycle pulse per LE.
- busy_o  out  1  high while not in IDLE.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_we_i  in  1  Wishbone write enable.
- wbs_sel_i  in  4  Wishbone byte selects.
- wbs_adr_i  in  32  Wishbone address; only [3:2] decoded.
- wbs_dat_i  in  32  Wishbone write data.
- wbs_ack_o  out  1  Wishbone acknowledge.
- wbs_dat_o  out  32  Wishbone read data.

Behaviour:
- Clock and reset: one clock, wb_clk_i. wb_rst_ni is asynchronous and active-low.
- Reset values: all outputs 0; state IDLE; counters 0; error flags 0; CTRL = {dt=DEFAULT_DT, vc=DEFAULT_VC, en=0}.
- Header word decode:
  - DI = byte0, with VC = DI[7:6] and DT = DI[5:0].
  - WC = {byte2, byte1}.
  - byte3 is ECC and is ignored.
- Packet framing:
  - Every packet starts word-aligned.
  - Upstream delivers a packet's words back-to-back; word_valid_i gaps are allowed only between packets.
  - Bytes after the 2-byte CRC in the last word are filler.
- States: IDLE, PAYLOAD, DROP.
- IDLE: acts only on word_valid_i && en.
  - DT 0x00/0x01/0x02/0x03 (FS/FE/LS/LE) with VC match: pulse the matching strobe one cycle later; stay in IDLE. Short packets with VC mismatch are ignored.
  - FS additionally clears line_count. FE additionally increments frame_count, which wraps.
  - DT >= 0x10 (long packet): load rem = WC+2 (17-bit), pos = 0.
    - VC == vc && DT == dt && WC != 0 && WC%5 == 0: go to PAYLOAD.
    - VC and DT match but WC == 0 or WC%5 != 0: set wc_err, go to DROP.
    - VC or DT mismatch: go to DROP; no error.
  - Any other DT: ignored.
- PAYLOAD and DROP: each valid word updates rem -= 4 and pos += 4.
  - When rem <= 4 before the decrement, return to IDLE after this word.
- PAYLOAD forwarding:
  - Forward the word iff pos < WC.
  - unpack_data_o = word_i and unpack_valid_o = 1, registered, one cycle after acceptance.
  - Otherwise unpack_valid_o = 0.
- On PAYLOAD→IDLE, line_count increments (wraps).
- Data-word gaps inside PAYLOAD set seq_err (sticky); the state is held.
- Clearing en in any state: next cycle state is IDLE and unpack_valid_o is 0; the partial packet is discarded with no line_count increment.
- An async reset mid-packet takes effect immediately; outputs go to 0.
- Wishbone interface:
  - valid = stb && cyc.
  - wbs_ack_o pulses one cycle after valid and never on back-to-back cycles. The same valid-&&-!ack rule as the other user-project blocks applies.
  - Reads are registered with the ack.
- Register map by adr[3:2]:
  - 0 CTRL, RW: [0] en, [2:1] vc, [8:3] dt. Bytes are written only where sel is set.
  - 1 CNT, RO: [15:0] frame_count, [31:16] line_count.
  - 2 ERR: [0] wc_err, [1] seq_err. Write-1-to-clear; sel[0] required.
  - 3: reads 0; writes ignored.
- Simultaneous events: a hardware error set in the same cycle as a W1C clear of that bit leaves the bit set.

Decomposition:
- Shared package mipi_csi_pkg holds:
  - DT_FS = 6'h00, DT_FE = 6'h01, DT_LS = 6'h02, DT_LE = 6'h03, DT_RAW10 = 6'h2B, LONG_DT_MIN = 6'h10.
  - State enum {IDLE, PAYLOAD, DROP}.
  - Register offsets CTRL/CNT/ERR.
- One natural sub-module, mipi_rx_ctrl_regs: Wishbone decode, CTRL/ERR registers, ack generation. The packet FSM stays in the top.

Test Plan:
1. Assert wb_rst_ni = 0 mid-run -> all outputs 0 immediately; after release, a CTRL read returns 0x0000_0158 and CNT reads 0.
2. en = 1, word 0x0000_0000 (FS VC0) -> frame_start_o is high exactly one cycle, one cycle later; line_count = 0. Word 0x0000_0001 (FE) -> frame_end_o pulse, frame_count = 1.
3. Header 0x5A00_0A2B (WC = 10) followed by 3 contiguous words A, B, C -> unpack_valid_o high for 3 cycles carrying A, B, C. busy_o then falls, and CNT[31:16] = 1.
4. Header 0x0000_072B (WC = 7) followed by 3 words -> unpack_valid_o stays 0, ERR reads 0x1. Writing 0x1 to ERR then reads 0x0.
5. Header 0x0000_0A6B (VC1 mismatch) followed by 3 words -> dropped, no error, line_count unchanged. The next matching header is processed normally.
6. WC = 20 packet: clear en after the 2nd payload word -> unpack_valid_o goes 0 the next cycle and line_count is unchanged. A gap inside PAYLOAD with en = 1 sets ERR[1].
